fp_add_arbiter: RTL

Shares one single-precision floating-point adder (registered output, ADD_LAT clock cycles from operand sample to result) among NUM_REQ requesters. The power-function datapath uses it so that several sequencing engines can use one adder instance without each building its own.
- Round-robin arbitration.
- One operation accepted per cycle; the adder is fully pipelined.
- Result routed back to the originating requester via a per-requester holding register with a valid/ready handshake.

---
 rtl/fp_add_pkg.sv | 17 +
 rtl/fp_add_arbiter_rr_arbiter.sv | 31 +++
 rtl/fp_add_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared single-precision float definitions for the adder-sharing datapath.
package fp_add_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [IDX_W-1:0] cand;

  // Scan from ptr upward with wraparound; the first hit wins and later hits are masked.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!gnt_any && eligible[cand]) begin
        grant[cand] = 1'b1;
        gnt_idx     = cand;
        gnt_any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one pipelined FP adder among NUM_REQ requesters: round-robin issue,
// a tag pipe that follows each operation through the adder, and one holding
// register per requester that keeps the sum until the requester takes it.
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 1,
  parameter int FP_W    = fp_add_pkg::FP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [NUM_REQ*FP_W-1:0] rsp_data,
  output logic [FP_W-1:0]         add_a,
  output logic [FP_W-1:0]         add_b,
  input  logic [FP_W-1:0]         add_c,
  output logic [15:0]             issue_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // busy[i] covers the whole life of an operation: accept -> adder -> held -> consumed.
  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [IDX_W-1:0]   ptr;
  logic [FP_W-1:0]    gnt_a;
  logic [FP_W-1:0]    gnt_b;

  // Issue stage registers (aligned with the operands presented to the adder).
  logic [FP_W-1:0]    add_a_p0;
  logic [FP_W-1:0]    add_b_p0;
  logic               vld_p0;
  logic [IDX_W-1:0]   id_p0;
  logic [15:0]        issue_cnt_r;

  // Tag pipe; stage ADD_LAT lines up with add_c.
  logic               vld_p [1:ADD_LAT];
  logic [IDX_W-1:0]   id_p  [1:ADD_LAT];

  logic [NUM_REQ-1:0] cap_oh;
  logic [NUM_REQ-1:0] consume;
  logic [NUM_REQ-1:0] rsp_valid_r;
  logic [FP_W-1:0]    rsp_data_r [NUM_REQ];

  assign eligible = req_valid & ~busy;
  assign consume  = rsp_valid_r & rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  // grant is only ever raised for an eligible (hence valid) requester, so
  // every grant is an accept.
  assign req_ready = grant;
  assign gnt_a     = req_a[int'(gnt_idx)*FP_W +: FP_W];
  assign gnt_b     = req_b[int'(gnt_idx)*FP_W +: FP_W];

  // ---- stage p0: accept, latch operands, advance pointer, count ----
  // Operands hold their value on idle cycles so the adder inputs do not toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_p0    <= FP_W'(FP_ZERO);
      add_b_p0    <= FP_W'(FP_ZERO);
      vld_p0      <= 1'b0;
      id_p0       <= '0;
      ptr         <= '0;
      issue_cnt_r <= 16'd0;
    end else begin
      vld_p0 <= gnt_any;
      if (gnt_any) begin
        add_a_p0    <= gnt_a;
        add_b_p0    <= gnt_b;
        id_p0       <= gnt_idx;
        ptr         <= (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
        issue_cnt_r <= issue_cnt_r + 16'd1;
      end
    end
  end

  assign add_a     = add_a_p0;
  assign add_b     = add_b_p0;
  assign issue_cnt = issue_cnt_r;

  // ---- stages p1..pADD_LAT: tag travels alongside the operation in the adder ----
  // Only the valid bits need clearing; a stale id under vld=0 is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 1; s <= ADD_LAT; s++) vld_p[s] <= 1'b0;
    end else begin
      vld_p[1] <= vld_p0;
      for (int s = 2; s <= ADD_LAT; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // Id shift register paired with the valid chain above.
  always_ff @(posedge clk) begin
    id_p[1] <= id_p0;
    for (int s = 2; s <= ADD_LAT; s++) id_p[s] <= id_p[s-1];
  end

  // Decode which holding register the emerging sum belongs to.
  always_comb begin
    cap_oh = '0;
    if (vld_p[ADD_LAT]) cap_oh[id_p[ADD_LAT]] = 1'b1;
  end

  // ---- capture: holding registers and busy flags ----
  // busy blocks re-issue, so a capture never lands on an unconsumed result
  // of the same requester; different requesters are fully independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      rsp_valid_r <= '0;
      for (int i = 0; i < NUM_REQ; i++) rsp_data_r[i] <= FP_W'(FP_ZERO);
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i])        busy[i] <= 1'b1;
        else if (consume[i]) busy[i] <= 1'b0;

        if (cap_oh[i]) begin
          rsp_valid_r[i] <= 1'b1;
          rsp_data_r[i]  <= add_c;
        end else if (consume[i]) begin
          rsp_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_r;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    assign rsp_data[g*FP_W +: FP_W] = rsp_data_r[g];
  end

endmodule
